alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU and its ALUControl decode between two requesters, e.g. the

---
 rtl/alu_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU: issue register
// drives the ALU, response register returns tagged results. Optional grant counters: ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_aluop,
  input  logic              req0_op5,
  input  logic              req0_func75,
  input  logic [2:0]        req0_func3,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_aluop,
  input  logic              req1_op5,
  input  logic              req1_func75,
  input  logic [2:0]        req1_func3,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [2:0]        alu_aluop,
  output logic              alu_op5,
  output logic              alu_func75,
  output logic [2:0]        alu_func3,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [XLEN-1:0]   rsp_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  // Handshake: a request transfers on a rising edge where reqN_valid & reqN_ready are both high;
  // a response transfers where rsp_valid & rsp_ready are both high. Ready never depends on a
  // later cycle, and a valid request or response holds its payload until it transfers.

  if (STAT_W < 1) begin : g_stat_w_check
    $error("STAT_W must be at least 1");
  end

  logic              rr_ptr;
  logic              winner;
  logic              any_valid;
  logic              accept;
  logic              s1_free;
  logic              s2_adv;

  logic              s1_valid;
  logic              s1_id;
  logic [2:0]        s1_aluop;
  logic              s1_op5;
  logic              s1_func75;
  logic [2:0]        s1_func3;
  logic [XLEN-1:0]   s1_a;
  logic [XLEN-1:0]   s1_b;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid;
  logic              s2_id;
  logic [TAG_W-1:0]  s2_tag;
  logic [XLEN-1:0]   s2_result;

  assign s2_adv    = s1_valid & (~s2_valid | rsp_ready);
  assign s1_free   = ~s1_valid | s2_adv;
  assign any_valid = req0_valid | req1_valid;

  // Only valid requesters compete; the pointer breaks ties.
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid) winner = rr_ptr;
  end

  assign accept     = any_valid & s1_free & ~rst;
  assign req0_ready = accept & ~winner;
  assign req1_ready = accept & winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_id     <= 1'b0;
      s1_aluop  <= '0;
      s1_op5    <= 1'b0;
      s1_func75 <= 1'b0;
      s1_func3  <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
    end else begin
      if (accept) rr_ptr <= ~winner;
      if (s1_free) s1_valid <= accept;
      if (accept) begin
        s1_id     <= winner;
        s1_aluop  <= winner ? req1_aluop  : req0_aluop;
        s1_op5    <= winner ? req1_op5    : req0_op5;
        s1_func75 <= winner ? req1_func75 : req0_func75;
        s1_func3  <= winner ? req1_func3  : req0_func3;
        s1_a      <= winner ? req1_a      : req0_a;
        s1_b      <= winner ? req1_b      : req0_b;
        s1_tag    <= winner ? req1_tag    : req0_tag;
      end
    end
  end

  // The ALU sees zeros whenever the issue register is empty.
  assign alu_aluop  = s1_valid ? s1_aluop  : '0;
  assign alu_op5    = s1_valid & s1_op5;
  assign alu_func75 = s1_valid & s1_func75;
  assign alu_func3  = s1_valid ? s1_func3  : '0;
  assign alu_a      = s1_valid ? s1_a      : '0;
  assign alu_b      = s1_valid ? s1_b      : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_id     <= 1'b0;
      s2_tag    <= '0;
      s2_result <= '0;
    end else if (s2_adv) begin
      s2_valid  <= 1'b1;
      s2_id     <= s1_id;
      s2_tag    <= s1_tag;
      s2_result <= alu_result;
    end else if (rsp_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = s2_valid;
  assign rsp_id     = s2_id;
  assign rsp_tag    = s2_tag;
  assign rsp_result = s2_result;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a small ALU model closes the loop and a scoreboard
// checks every response against the request that produced it.
module tb_alu_share_arbiter;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  localparam int STAT_W = 4;
  localparam int SB_W   = 1 + TAG_W + XLEN;

  logic              clk;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [2:0]        req0_aluop, req1_aluop;
  logic              req0_op5, req1_op5;
  logic              req0_func75, req1_func75;
  logic [2:0]        req0_func3, req1_func3;
  logic [XLEN-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0]  req0_tag, req1_tag;
  logic [2:0]        alu_aluop;
  logic              alu_op5, alu_func75;
  logic [2:0]        alu_func3;
  logic [XLEN-1:0]   alu_a, alu_b, alu_result;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic [XLEN-1:0]   rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int passes = 0;
  logic [SB_W-1:0] exp_q[$];

  function automatic logic [XLEN-1:0] alu_model(input logic [2:0] op, input logic o5,
      input logic f75, input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = a + b;
    if (op == 3'b001) r = a - b;
    else if (op == 3'b010) begin
      case (f3)
        3'b000: r = (o5 && f75) ? a - b : a + b;
        3'b100: r = a ^ b;
        3'b110: r = a | b;
        3'b111: r = a & b;
        default: r = a + b;
      endcase
    end
    return r;
  endfunction

  assign alu_result = alu_model(alu_aluop, alu_op5, alu_func75, alu_func3, alu_a, alu_b);

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_op5(req0_op5), .req0_func75(req0_func75), .req0_func3(req0_func3),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_op5(req1_op5), .req1_func75(req1_func75), .req1_func3(req1_func3),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_aluop(alu_aluop), .alu_op5(alu_op5), .alu_func75(alu_func75),
    .alu_func3(alu_func3), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; the negedge sees what the next edge transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready)
        exp_q.push_back({1'b0, req0_tag,
          alu_model(req0_aluop, req0_op5, req0_func75, req0_func3, req0_a, req0_b)});
      if (req1_valid && req1_ready)
        exp_q.push_back({1'b1, req1_tag,
          alu_model(req1_aluop, req1_op5, req1_func75, req1_func3, req1_a, req1_b)});
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL rsp_unexpected: got id=%0d tag=%0h res=%h, expected no response",
                   rsp_id, rsp_tag, rsp_result);
        else begin
          logic [SB_W-1:0] e;
          e = exp_q.pop_front();
          if ({rsp_id, rsp_tag, rsp_result} !== e)
            $display("FAIL rsp_data: got id=%0d tag=%0h res=%h, expected id=%0d tag=%0h res=%h",
                     rsp_id, rsp_tag, rsp_result, e[SB_W-1], e[XLEN +: TAG_W], e[XLEN-1:0]);
          else passes++;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_aluop = 0; req0_op5 = 0; req0_func75 = 0; req0_func3 = 0;
    req0_a = 0; req0_b = 0; req0_tag = 0;
    req1_valid = 0; req1_aluop = 0; req1_op5 = 0; req1_func75 = 0; req1_func3 = 0;
    req1_a = 0; req1_b = 0; req1_tag = 0;
  endtask

  task automatic set_req(input int n, input logic [2:0] op, input logic o5, input logic f75,
      input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
      input logic [TAG_W-1:0] tag);
    if (n == 0) begin
      req0_valid = 1; req0_aluop = op; req0_op5 = o5; req0_func75 = f75; req0_func3 = f3;
      req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1; req1_aluop = op; req1_op5 = o5; req1_func75 = f75; req1_func3 = f3;
      req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    step(); step();
    rst = 0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rsp_valid)
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    else passes++;
  endtask

  // Issues one op and waits (bounded) for its response.
  task automatic issue_and_wait(input int n, input logic [2:0] op, input logic o5,
      input logic f75, input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
      input logic [TAG_W-1:0] tag, output logic [XLEN-1:0] res, output logic ok);
    int k;
    rsp_ready = 1;
    set_req(n, op, o5, f75, f3, a, b, tag);
    k = 0;
    @(negedge clk);
    while (!(n == 0 ? req0_ready : req1_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    step();
    req0_valid = 0; req1_valid = 0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = rsp_valid;
    res = rsp_result;
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    rsp_ready = 1;
    idle_inputs();
    req0_valid = 1; req1_valid = 1;
    step(); step();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL reset_ready: got %b%b, expected 00", req0_ready, req1_ready);
    else passes++;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== '0 || alu_a !== '0 || alu_aluop !== 3'd0)
      $display("FAIL reset_outputs: rsp_valid=%b rsp_result=%h alu_a=%h, expected all 0",
               rsp_valid, rsp_result, alu_a);
    else passes++;
    idle_inputs();
    rst = 0;
    exp_q.delete();
    step();
  endtask

  task automatic test_single();
    set_req(0, 3'b000, 0, 0, 3'b000, 5, 7, 3);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL t1_ready: got %b%b, expected req0=1 req1=0", req0_ready, req1_ready);
    else passes++;
    step();
    req0_valid = 0;
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || rsp_valid !== 1'b0)
      $display("FAIL t1_issue: got alu_a=%0d alu_b=%0d rsp_valid=%b, expected 5 7 0",
               alu_a, alu_b, rsp_valid);
    else passes++;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd3 || rsp_result !== 32'd12)
      $display("FAIL t1_latency: got v=%b id=%0d tag=%0d res=%0d, expected 1 0 3 12",
               rsp_valid, rsp_id, rsp_tag, rsp_result);
    else passes++;
    drain();
  endtask

  task automatic test_alternate();
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 3'b000, 0, 0, 3'b000, $urandom, $urandom, 4'(2 * i));
      set_req(1, 3'b010, 0, 0, 3'b111, $urandom, $urandom, 4'(2 * i + 1));
      @(negedge clk);
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1))
        $display("FAIL t2_grant%0d: got r0=%b r1=%b, expected r0=%b r1=%b",
                 i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
      else passes++;
      if (i >= 3) begin
        checks++;
        if (rsp_valid !== 1'b1)
          $display("FAIL t2_throughput%0d: got rsp_valid=%b, expected 1", i, rsp_valid);
        else passes++;
      end
      step();
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [SB_W-1:0] held;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 3'b010, 0, 0, 3'b100, $urandom, $urandom, 4'(i + 8));
      @(negedge clk);
      checks++;
      if (req0_ready !== (i < 2))
        $display("FAIL t3_ready%0d: got %b, expected %b", i, req0_ready, i < 2);
      else passes++;
      if (i == 2) held = {rsp_id, rsp_tag, rsp_result};
      if (i > 2) begin
        checks++;
        if ({rsp_id, rsp_tag, rsp_result} !== held || rsp_valid !== 1'b1)
          $display("FAIL t3_stable%0d: got tag=%0h res=%h, expected tag=%0h res=%h",
                   i, rsp_tag, rsp_result, held[XLEN +: TAG_W], held[XLEN-1:0]);
        else passes++;
      end
      step();
    end
    checks++;
    if (exp_q.size() != 2)
      $display("FAIL t3_accepted: got %0d accepted, expected 2", exp_q.size());
    else passes++;
    drain();
  endtask

  task automatic test_sub();
    logic [XLEN-1:0] res;
    logic ok;
    issue_and_wait(1, 3'b010, 1, 1, 3'b000, 10, 3, 4'hA, res, ok);
    checks++;
    if (!ok || res !== 32'd7)
      $display("FAIL t4_sub: got ok=%b res=%h, expected 00000007", ok, res);
    else passes++;
    issue_and_wait(0, 3'b010, 1, 1, 3'b000, 0, 1, 4'hB, res, ok);
    checks++;
    if (!ok || res !== 32'hFFFF_FFFF)
      $display("FAIL t4_sub_wrap: got ok=%b res=%h, expected ffffffff", ok, res);
    else passes++;
    drain();
  endtask

  task automatic test_reset_midstream();
    int k;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 3'b000, 0, 0, 3'b000, $urandom, $urandom, 4'(i));
      step();
    end
    #2 rst = 1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_a !== '0)
      $display("FAIL t5_async: got rsp_valid=%b alu_a=%h, expected 0 0", rsp_valid, alu_a);
    else passes++;
    exp_q.delete();
    idle_inputs();
    step();
    rst = 0;
    rsp_ready = 1;
    set_req(0, 3'b000, 0, 0, 3'b000, 100, 1, 4'hE);
    set_req(1, 3'b000, 0, 0, 3'b000, 200, 2, 4'hD);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL t5_rr_ptr: got r0=%b r1=%b, expected r0=1 r1=0", req0_ready, req1_ready);
    else passes++;
    step();
    idle_inputs();
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'hE || rsp_result !== 32'd101)
      $display("FAIL t5_first_rsp: got v=%b tag=%0h res=%0d, expected 1 e 101",
               rsp_valid, rsp_tag, rsp_result);
    else passes++;
    step();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      if ($urandom_range(0, 3) != 0)
        set_req(0, 3'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 3'($urandom),
                $urandom, $urandom, 4'($urandom));
      if ($urandom_range(0, 3) != 0)
        set_req(1, 3'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 3'($urandom),
                $urandom, $urandom, 4'($urandom));
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 17; i++) begin
      set_req(1, 3'b000, 0, 0, 3'b000, i, 1, 4'(i));
      step();
    end
    drain();
    checks++;
    if (grant_cnt1 !== 4'd1 || grant_cnt0 !== 4'd0)
      $display("FAIL t6_stats: got cnt0=%0d cnt1=%0d, expected 0 1", grant_cnt0, grant_cnt1);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_sub();
    test_reset_midstream();
    test_back_to_back();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
